// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and constants for the SRAM responder.
// Byte-lane helper lives here so the top stays compact.
package ahb_lite_sram_slave_pkg;

  localparam int SLAVE_DATAWIDTH = 32;
  localparam int SLAVE_ADDRWIDTH = 10;
  localparam int SLAVE_MEM_BYTES = 4 << SLAVE_ADDRWIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } HTRANS_TYPE;

  typedef enum logic [2:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2,
    WORD2    = 3'd3,
    WORD4    = 3'd4,
    WORD8    = 3'd5,
    WORD16   = 3'd6,
    WORD32   = 3'd7
  } HSIZE_TYPE;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_TYPE;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } HWRITE_TYPE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } SLV_STATE_TYPE;

  // Little-endian lane enables; sizes above WORD never reach a data phase.
  function automatic logic [3:0] f_byte_en(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    if (size == 3'(BYTE)) begin
      be = 4'b0001 << a;
    end else if (size == 3'(HALFWORD)) begin
      be = a[1] ? 4'b1100 : 4'b0011;
    end
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bytewise.sv
// Word-organised SRAM array with per-byte write enables.
// Read port is combinational so a fresh write is visible next cycle.
module ahb_sram_bytewise #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Byte-lane write; contents deliberately have no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: address/data pipelining, wait states,
// two-cycle ERROR response and byte-lane writes.
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int SLAVE_DATAWIDTH = 32,
  parameter int SLAVE_ADDRWIDTH = 10,
  parameter int WAIT_STATES     = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [SLAVE_DATAWIDTH-1:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [SLAVE_DATAWIDTH-1:0] HRDATA
);

  localparam int AW = SLAVE_ADDRWIDTH;

  SLV_STATE_TYPE r_state;
  logic          r_hreadyout;
  logic          r_hresp;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic          r_write;
  logic [2:0]    r_size;

  logic          w_accept;
  logic          w_err;
  logic          w_we;
  logic [3:0]    w_be;
  logic [SLAVE_DATAWIDTH-1:0] w_rdata;
  logic          w_unused;

  assign w_unused = ^HBURST;

  // NONSEQ and SEQ both have HTRANS[1] set.
  assign w_accept = HSEL & HREADY & HTRANS[1];

  assign w_err = (|HADDR[31:AW+2])
               | (HSIZE > 3'(WORD))
               | ((HSIZE == 3'(HALFWORD)) & HADDR[0])
               | ((HSIZE == 3'(WORD)) & (|HADDR[1:0]));

  // Control FSM with registered bus responses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= OKAY;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
    end else begin
      unique case (r_state)
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= ERROR;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= HADDR[AW+1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            if (w_err) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= ERROR;
              r_cnt       <= '0;
            end else if (WAIT_STATES == 0) begin
              r_state     <= ST_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= OKAY;
              r_cnt       <= '0;
            end else begin
              r_state     <= ST_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= OKAY;
              r_cnt       <= 4'(WAIT_STATES);
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY;
          end
        end
      endcase
    end
  end

  assign w_we = (r_state == ST_DATA) & r_write;
  assign w_be = f_byte_en(r_size, r_addr[1:0]);

  ahb_sram_bytewise #(
    .AW (AW),
    .DW (SLAVE_DATAWIDTH)
  ) u_mem (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) on one bus.
// Idle responders drive HREADYOUT=1, so the HREADY mux is an AND.
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  sel;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [2:0]  ro;
  logic [2:0]  rs;
  logic [31:0] rd0, rd1, rd2;
  logic        HREADY;
  logic        hresp;
  logic [31:0] hrdata;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int c0;
  logic [31:0] rdv;

  always #5 HCLK = ~HCLK;

  assign HREADY = &ro;
  assign hresp  = |rs;
  assign hrdata = rd0 | rd1 | rd2;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[0]), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[0]),
    .HRESP(rs[0]), .HRDATA(rd0));

  ahb_lite_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[1]), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[1]),
    .HRESP(rs[1]), .HRDATA(rd1));

  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[2]), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[2]),
    .HRESP(rs[2]), .HRDATA(rd2));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    ncyc++;
  endtask

  task automatic addr_ph(input logic [2:0] s, input logic [31:0] a,
                         input logic w, input logic [2:0] sz,
                         input logic [1:0] tr);
    sel    = s;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HTRANS = tr;
  endtask

  task automatic idle();
    HTRANS = 2'd0;
  endtask

  // Single non-pipelined transfer; returns HRDATA seen in the data cycle.
  task automatic xfer(input logic [2:0] s, input logic [31:0] a,
                      input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input int nwait,
                      output logic [31:0] rdo);
    addr_ph(s, a, w, sz, 2'd2);
    tick();
    HWDATA = wd;
    idle();
    repeat (nwait) tick();
    rdo = hrdata;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    sel = 3'b000; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = 3'd0; HTRANS = 2'd0; HWDATA = '0;
    #23;
    chk("rst_ready", {29'd0, ro}, 32'h7);
    chk("rst_resp",  {29'd0, rs}, 32'h0);
    chk("rst_rdata", hrdata, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();

    // 1: pipelined write then read of the same word, zero wait
    addr_ph(3'b001, 32'h10, 1'b1, 3'd2, 2'd2);
    tick();
    HWDATA = 32'hDEADBEEF;
    addr_ph(3'b001, 32'h10, 1'b0, 3'd2, 2'd2);
    chk("t1_wr_ready", {31'd0, HREADY}, 32'h1);
    chk("t1_wr_resp",  {31'd0, hresp}, 32'h0);
    tick();
    idle();
    chk("t1_rd_ready", {31'd0, HREADY}, 32'h1);
    chk("t1_rd_data",  hrdata, 32'hDEADBEEF);
    tick();
    chk("t1_idle_data", hrdata, 32'h0);

    // BUSY while selected is no access: stays zero-wait OKAY
    addr_ph(3'b001, 32'h10, 1'b0, 3'd2, 2'd1);
    tick();
    chk("busy_ready", {31'd0, HREADY}, 32'h1);
    chk("busy_data",  hrdata, 32'h0);
    idle();

    // 2: byte writes into a zeroed word
    xfer(3'b001, 32'h20, 1'b1, 3'd2, 32'h0, 0, rdv);
    addr_ph(3'b001, 32'h21, 1'b1, 3'd0, 2'd2);
    tick();
    HWDATA = 32'h11111111;
    addr_ph(3'b001, 32'h23, 1'b1, 3'd0, 2'd2);
    tick();
    HWDATA = 32'h22222222;
    addr_ph(3'b001, 32'h20, 1'b0, 3'd2, 2'd2);
    tick();
    idle();
    chk("t2_bytes", hrdata, 32'h22001100);
    tick();

    // 3: INCR4 writes with two wait states
    HBURST = 3'd3;
    addr_ph(3'b010, 32'h40, 1'b1, 3'd2, 2'd2);
    c0 = ncyc;
    for (int i = 0; i < 4; i++) begin
      tick();
      HWDATA = 32'hA0000000 + 32'(i);
      if (i < 3) addr_ph(3'b010, 32'h44 + 32'(4*i), 1'b1, 3'd2, 2'd3);
      else idle();
      chk($sformatf("t3_w0_b%0d", i), {31'd0, HREADY}, 32'h0);
      tick();
      chk($sformatf("t3_w1_b%0d", i), {31'd0, HREADY}, 32'h0);
      tick();
      chk($sformatf("t3_rdy_b%0d", i), {31'd0, HREADY}, 32'h1);
    end
    chk("t3_cycles", 32'(ncyc - c0), 32'd12);
    tick();
    HBURST = 3'd0;
    for (int i = 0; i < 4; i++) begin
      xfer(3'b010, 32'h40 + 32'(4*i), 1'b0, 3'd2, 32'h0, 2, rdv);
      chk($sformatf("t3_rb%0d", i), rdv, 32'hA0000000 + 32'(i));
    end

    // 4: out-of-range read gives two-cycle ERROR
    xfer(3'b001, 32'h0, 1'b1, 3'd2, 32'hA5A5A5A5, 0, rdv);
    addr_ph(3'b001, 32'h1000, 1'b0, 3'd2, 2'd2);
    tick();
    idle();
    chk("t4_e1", {30'd0, HREADY, hresp}, 32'h1);
    tick();
    chk("t4_e2", {30'd0, HREADY, hresp}, 32'h3);
    addr_ph(3'b001, 32'h0, 1'b0, 3'd2, 2'd2);
    tick();
    idle();
    chk("t4_ok", {30'd0, HREADY, hresp}, 32'h2);
    chk("t4_data", hrdata, 32'hA5A5A5A5);
    tick();

    // 5: misaligned halfword and oversize writes are refused
    addr_ph(3'b001, 32'h3, 1'b1, 3'd1, 2'd2);
    tick();
    HWDATA = 32'hFFFFFFFF;
    idle();
    chk("t5_h_e1", {30'd0, HREADY, hresp}, 32'h1);
    tick();
    chk("t5_h_e2", {30'd0, HREADY, hresp}, 32'h3);
    addr_ph(3'b001, 32'h0, 1'b1, 3'd3, 2'd2);
    tick();
    idle();
    chk("t5_s_e1", {30'd0, HREADY, hresp}, 32'h1);
    tick();
    chk("t5_s_e2", {30'd0, HREADY, hresp}, 32'h3);
    tick();
    xfer(3'b001, 32'h0, 1'b0, 3'd2, 32'h0, 0, rdv);
    chk("t5_nowrite", rdv, 32'hA5A5A5A5);

    // 6: reset during a wait state drops the pending write
    xfer(3'b100, 32'h80, 1'b1, 3'd2, 32'hCAFEF00D, 3, rdv);
    addr_ph(3'b100, 32'h80, 1'b1, 3'd2, 2'd2);
    tick();
    HWDATA = 32'h0BADF00D;
    idle();
    chk("t6_wait", {30'd0, HREADY, hresp}, 32'h0);
    tick();
    HRESET = 1'b1;
    #1;
    chk("t6_rst", {30'd0, HREADY, hresp}, 32'h2);
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
    xfer(3'b100, 32'h80, 1'b0, 3'd2, 32'h0, 3, rdv);
    chk("t6_old", rdv, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite single-port SRAM responder: the DUT the AHB-Lite master environment drives.
- Decodes address/control phases and pipelines them into data phases.
- Stores HWDATA into a 2^SLAVE_ADDRWIDTH-word memory with byte-lane writes, and returns HRDATA.
- Inserts programmable wait states and produces the two-cycle ERROR response.
- Sits behind the system decoder (HSEL) and the default HREADY mux.

Parameters:
SLAVE_DATAWIDTH, 32, data bus width; only 32 supported.
SLAVE_ADDRWIDTH, 10, word-address width; memory depth 1024 words (4 KB).
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
HCLK  in  1  bus clock; all state on rising edge.
HRESET  in  1  reset; asynchronous, active-high.
HSEL  in  1  slave select from decoder.
HADDR  in  32  byte address (address phase).
HWRITE  in  1  1=WRITE, 0=READ.
HSIZE  in  3  HSIZE_TYPE.
HBURST  in  3  HBURST_TYPE; informational only, no effect on behaviour.
HTRANS  in  2  HTRANS_TYPE.
HWDATA  in  32  write data (data phase).
HREADY  in  1  bus-level ready (muxed HREADYOUT of all slaves).
HREADYOUT  out  1  this slave's ready.
HRESP  out  1  HRESP_TYPE: OKAY/ERROR.
HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset (async assert, sync release): HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=ST_IDLE, wait counter=0, latched control cleared. Memory contents are not reset.
- Address-phase accept condition: HSEL & HREADY & HTRANS in {NONSEQ, SEQ}. On accept, latch HADDR[SLAVE_ADDRWIDTH+1:0], HWRITE, HSIZE, and an error flag.
- HSEL & HREADY with HTRANS in {IDLE, BUSY}: no access; the next cycle is zero-wait OKAY.
- If HREADY=0, nothing is sampled.
- Error flag is set when any of these hold:
  - HADDR[31:SLAVE_ADDRWIDTH+2] != 0;
  - HSIZE > WORD;
  - HALFWORD with HADDR[0]=1;
  - WORD with HADDR[1:0] != 0.
- FSM states:
  - ST_IDLE: no pending data phase; HREADYOUT=1, HRESP=OKAY.
    - Accept with error → ST_ERR1.
    - Accept without error and WAIT_STATES=0 → ST_DATA with count 0.
    - Accept without error and WAIT_STATES>0 → ST_WAIT with count loaded to WAIT_STATES.
  - ST_WAIT: HREADYOUT=0, HRESP=OKAY. Count decrements each cycle; at count=1 → ST_DATA.
  - ST_DATA: HREADYOUT=1, HRESP=OKAY; the transfer completes this cycle.
    - Write: mem[word addr] updated at this clock edge with byte enables from HSIZE and addr[1:0], little-endian lanes.
    - Read: HRDATA = full 32-bit word mem[word addr]; the master extracts lanes.
    - A new accept in the same cycle (pipelined) → next state per the ST_IDLE rules; otherwise → ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=ERROR → ST_ERR2. No memory access.
  - ST_ERR2: HREADYOUT=1, HRESP=ERROR. The master may issue IDLE or a new transfer; an accept follows the ST_IDLE rules.
- Latency: with WAIT_STATES=N, the OKAY data phase lasts N+1 cycles. Back-to-back pipelined transfers run at one transfer per (N+1) cycles.
- Read-after-write to the same word, back-to-back: the write commits at the end of its data phase, before the read's data phase. The read returns the new data; no forwarding is needed.
- HRDATA is 0 outside a read ST_DATA cycle.
- Reset asserted mid data phase: the pending write is discarded and the FSM returns to ST_IDLE.
- HSEL low during our own data phase does not abort the data phase.

Decomposition:
- AHBpkg gains: `typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2}` (widened to 3 bits), named SLV_STATE_TYPE.
- AHBpkg also gains a constant SLAVE_MEM_BYTES = 4 << SLAVE_ADDRWIDTH.
- The existing HTRANS_TYPE, HSIZE_TYPE, HRESP_TYPE, HWRITE_TYPE and SLAVE_* parameters are reused.
- One sub-module, ahb_sram_bytewise: a 1024x32 array with a 4-bit byte-enable write port and an asynchronous read port, instantiated once.

Test Plan:
1. WAIT_STATES=0: WORD write 0xDEADBEEF @0x10, then READ @0x10 → both zero-wait OKAY; HRDATA=0xDEADBEEF one cycle after the read address phase.
2. BYTE writes 0x11 @0x21 and 0x22 @0x23 over word 0x00000000, then WORD read @0x20 → HRDATA=0x22001100.
3. WAIT_STATES=2: NONSEQ+3 SEQ INCR4 WORD writes @0x40..0x4C → HREADYOUT pattern 0,0,1 per beat; 12 cycles total. Read-back returns the written values.
4. WORD read @0x00001000 (out of range) → HREADYOUT 0/HRESP ERROR, then 1/ERROR; memory unchanged. A following OKAY read @0x0 completes normally.
5. Misaligned HALFWORD @0x3 and HSIZE=WORD2 @0x0 → each gives the two-cycle ERROR; no write occurs.
6. Assert HRESET during ST_WAIT of a write (WAIT_STATES=3) → HREADYOUT=1, HRESP=OKAY immediately; a later read of that address shows the old data.
